// File: rtl/mem_seq_pkg.sv
// Shared op codes, FSM states and decode helpers for the load/store sequencer.
package mem_seq_pkg;

  localparam logic [2:0] LB_MOP = 3'b000;
  localparam logic [2:0] LH_MOP = 3'b001;
  localparam logic [2:0] LW_MOP = 3'b010;
  localparam logic [2:0] SB_MOP = 3'b100;
  localparam logic [2:0] SH_MOP = 3'b101;
  localparam logic [2:0] SW_MOP = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_e;

  function automatic logic is_load(input logic [2:0] op);
    return (op == LB_MOP) || (op == LH_MOP) || (op == LW_MOP);
  endfunction

  // Unknown op codes report as a fault so the control FSM never hangs on them.
  function automatic logic is_fault(input logic [2:0] op, input logic [1:0] a);
    logic f;
    case (op)
      LB_MOP, SB_MOP: f = 1'b0;
      LH_MOP, SH_MOP: f = a[0];
      LW_MOP, SW_MOP: f = (a != 2'b00);
      default:        f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/mem_seq_lane.sv
// Byte/half lane steering: sign-extended load extraction and store lane merge.
module mem_lane
  import mem_seq_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  op,
  input  logic [31:0] store_data,
  output logic [31:0] load_ext,
  output logic [31:0] store_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b     = word[{addr_lo, 3'b000} +: 8];
    lane_h     = word[{addr_lo[1], 4'b0000} +: 16];
    load_ext   = word;
    store_word = word;
    case (op)
      LB_MOP:  load_ext = {{24{lane_b[7]}}, lane_b};
      LH_MOP:  load_ext = {{16{lane_h[15]}}, lane_h};
      SB_MOP:  store_word[{addr_lo, 3'b000} +: 8] = store_data[7:0];
      SH_MOP:  store_word[{addr_lo[1], 4'b0000} +: 16] = store_data[15:0];
      SW_MOP:  store_word = store_data;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_seq.sv
// Load/store sequencer: runs one memory op per start, including RMW for sub-word stores.
module mem_seq
  import mem_seq_pkg::*;
#(
  parameter int MEM_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        busy,
  output logic        done,
  output logic        misalign
);

  localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  alo_q, alo_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_wr_q, mem_wr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        misalign_q, misalign_d;

  logic [31:0] lane_load;
  logic [31:0] lane_store;

  mem_lane u_lane (
    .word       (mem_rdata),
    .addr_lo    (alo_q),
    .op         (op_q),
    .store_data (sdata_q),
    .load_ext   (lane_load),
    .store_word (lane_store)
  );

  // Outputs are registered, so each transition loads the values the next state presents.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    alo_d        = alo_q;
    sdata_d      = sdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    load_data_d  = load_data_q;
    busy_d       = busy_q;
    mem_wr_d     = 1'b0;
    load_valid_d = 1'b0;
    done_d       = 1'b0;
    misalign_d   = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          op_d       = op;
          alo_d      = addr[1:0];
          sdata_d    = store_data;
          mem_addr_d = {addr[31:2], 2'b00};
          busy_d     = 1'b1;
          cnt_d      = '0;
          if (is_fault(op, addr[1:0])) begin
            state_d    = FIN;
            done_d     = 1'b1;
            misalign_d = 1'b1;
          end else if (op == SW_MOP) begin
            state_d     = WR;
            mem_wr_d    = 1'b1;
            mem_wdata_d = store_data;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          if (is_load(op_q)) begin
            state_d      = FIN;
            done_d       = 1'b1;
            load_valid_d = 1'b1;
            load_data_d  = lane_load;
          end else begin
            state_d     = WR;
            mem_wr_d    = 1'b1;
            mem_wdata_d = lane_store;
          end
        end
      end
      WR: begin
        state_d = FIN;
        done_d  = 1'b1;
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      alo_q        <= '0;
      sdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wr_q     <= 1'b0;
      mem_wdata_q  <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      alo_q        <= alo_d;
      sdata_q      <= sdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wr_q     <= mem_wr_d;
      mem_wdata_q  <= mem_wdata_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      misalign_q   <= misalign_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wr     = mem_wr_q;
  assign mem_wdata  = mem_wdata_q;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign misalign   = misalign_q;

endmodule
